// File: rtl/cascade_counter_pkg.sv
// cascade_counter_pkg
// Shared constants and helpers for the cascade_counter block:
//   - DEF_W / DEF_STAGES / DEF_MODS : default geometry (hours:minutes:seconds)
//   - DIR_UP / DIR_DOWN             : count direction encodings
//   - stage_slice()                 : extract stage i from a packed STAGES*W vector
package cascade_counter_pkg;

    localparam int DEF_W      = 6;
    localparam int DEF_STAGES = 3;
    // Stage 0 (seconds) sits in the low bits, stage 2 (hours) in the high bits.
    localparam logic [DEF_STAGES*DEF_W-1:0] DEF_MODS = {6'd24, 6'd60, 6'd60};

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Returns the w-bit field at [idx*w +: w] of a vector zero-extended to 1024 bits.
    function automatic logic [31:0] stage_slice(input logic [1023:0] vec,
                                                input int idx, input int w);
        logic [1023:0] sh;
        logic [1023:0] mask;
        mask = (1024'(1) << w) - 1024'(1);
        sh   = (vec >> (idx * w)) & mask;
        return sh[31:0];
    endfunction

endpackage

// File: rtl/cascade_counter_mod_stage.sv
// mod_stage
// One W-bit modulo-MOD up/down counter stage.
//   clk, reset : clock, synchronous active-high reset (value -> 0)
//   step       : advance one position this edge
//   dir        : DIR_UP / DIR_DOWN
//   value      : registered stage value, always in 0..MOD-1
//   term       : stage is at its terminal value for the current direction
module mod_stage
    import cascade_counter_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int MOD = 60
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    input  logic         dir,
    output logic [W-1:0] value,
    output logic         term
);

    localparam logic [W-1:0] TOP = W'(MOD - 1);

    logic [W-1:0] val_q;
    logic [W-1:0] val_d;

    always_comb begin
        term  = (dir == DIR_UP) ? (val_q == TOP) : (val_q == '0);
        val_d = val_q;
        if (step) begin
            if (dir == DIR_UP) val_d = term ? '0  : val_q + W'(1);
            else               val_d = term ? TOP : val_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) val_q <= '0;
        else       val_q <= val_d;
    end

    assign value = val_q;

endmodule

// File: rtl/cascade_counter.sv
// cascade_counter
// Chain of up/down modulo counters with ripple carry/borrow, plus a one-cycle
// wrap pulse when the whole chain rolls over. Optional adjust mode (macro
// CASCADE_COUNTER_ADJUST_EN) steps a single stage with no carry.
//   clk, reset      : clock, synchronous active-high reset
//   en              : count tick
//   updown          : 1 = up, 0 = down
//   adj_mode        : freeze counting, enable adjust inputs
//   adj_sel         : stage to adjust
//   adj_up/adj_down : step selected stage +1/-1 within its own modulus
//   count           : packed stage values (stage 0 in low bits)
//   wrap            : registered full-chain wrap pulse
module cascade_counter
    import cascade_counter_pkg::*;
#(
    parameter int                    STAGES = DEF_STAGES,
    parameter int                    W      = DEF_W,
    parameter logic [STAGES*W-1:0]   MODS   = DEF_MODS,
    localparam int                   SEL_W  = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                updown,
    input  logic                adj_mode,
    input  logic [SEL_W-1:0]    adj_sel,
    input  logic                adj_up,
    input  logic                adj_down,
    output logic [STAGES*W-1:0] count,
    output logic                wrap
);

    logic              cnt_step;
    logic              dir;
    logic [STAGES:0]   carry;
    logic [STAGES-1:0] term;
    logic [STAGES-1:0] step;
    logic [STAGES-1:0] adj_step;
    logic              wrap_q;
    logic              wrap_d;

`ifdef CASCADE_COUNTER_ADJUST_EN
    assign cnt_step = en & ~adj_mode;
    // During adjust the selected stage follows the adjust direction; the carry
    // chain is idle so its terminal flags are only used for in-stage wrap.
    assign dir      = adj_mode ? adj_up : updown;
`else
    logic unused_adj;
    assign unused_adj = ^{adj_mode, adj_sel, adj_up, adj_down};
    assign cnt_step   = en;
    assign dir        = updown;
`endif

    assign carry[0] = cnt_step;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        // A modulus of 2^W does not fit in a W-bit field and is encoded as 0.
        localparam int MOD_RAW = int'(stage_slice(1024'(MODS), i, W));
        localparam int MOD_I   = (MOD_RAW == 0) ? (2 ** W) : MOD_RAW;

`ifdef CASCADE_COUNTER_ADJUST_EN
        assign adj_step[i] = adj_mode & (adj_up ^ adj_down) & (adj_sel == SEL_W'(i));
`else
        assign adj_step[i] = 1'b0;
`endif

        assign carry[i+1] = carry[i] & term[i];
        assign step[i]    = carry[i] | adj_step[i];

        mod_stage #(
            .W   (W),
            .MOD (MOD_I)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .step  (step[i]),
            .dir   (dir),
            .value (count[i*W +: W]),
            .term  (term[i])
        );
    end

    // carry[STAGES] is a step with every stage terminal: the chain wraps.
    assign wrap_d = carry[STAGES];

    always_ff @(posedge clk) begin
        if (reset) wrap_q <= 1'b0;
        else       wrap_q <= wrap_d;
    end

    assign wrap = wrap_q;

endmodule

// File: tb/tb_cascade_counter.sv
module tb_cascade_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        updown;
    logic        adj_mode;
    logic [1:0]  adj_sel;
    logic        adj_up;
    logic        adj_down;
    logic [17:0] count;
    logic        wrap;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cascade_counter dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .updown   (updown),
        .adj_mode (adj_mode),
        .adj_sel  (adj_sel),
        .adj_up   (adj_up),
        .adj_down (adj_down),
        .count    (count),
        .wrap     (wrap)
    );

    function automatic logic [17:0] hms(input int h, input int m, input int s);
        return {6'(h), 6'(m), 6'(s)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk_st(input string tag, input logic [17:0] exp_cnt, input logic exp_wrap);
        chk({tag, ".count"}, 32'(count), 32'(exp_cnt));
        chk({tag, ".wrap"},  32'(wrap),  32'(exp_wrap));
    endtask

`ifdef CASCADE_COUNTER_ADJUST_EN
    task automatic pulse(input logic [1:0] sel, input logic up, input logic dn);
        adj_sel = sel; adj_up = up; adj_down = dn;
        tick();
        adj_up = 1'b0; adj_down = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b1; en = 1'b0; updown = 1'b1;
        adj_mode = 1'b0; adj_sel = 2'd0; adj_up = 1'b0; adj_down = 1'b0;
        tick();
        chk_st("reset", hms(0, 0, 0), 1'b0);

        reset = 1'b0; en = 1'b1; updown = 1'b1;
        tick();
        chk_st("up1", hms(0, 0, 1), 1'b0);
        ticks(2);
        chk_st("up3", hms(0, 0, 3), 1'b0);

        // Down through zero into 23:59:59 then 23:59:58
        updown = 1'b0;
        ticks(3);
        chk_st("down_to_0", hms(0, 0, 0), 1'b0);
        tick();
        chk_st("down_wrap", hms(23, 59, 59), 1'b1);
        tick();
        chk_st("down_58", hms(23, 59, 58), 1'b0);

        // Up rollover from 23:59:58
        updown = 1'b1;
        tick();
        chk_st("up_59", hms(23, 59, 59), 1'b0);
        tick();
        chk_st("up_wrap", hms(0, 0, 0), 1'b1);
        tick();
        chk_st("up_after_wrap", hms(0, 0, 1), 1'b0);

        en = 1'b0;
        tick();
        chk_st("hold", hms(0, 0, 1), 1'b0);

        // Reset mid-count with en still high
        en = 1'b1;
        ticks(40);
        chk_st("run41", hms(0, 0, 41), 1'b0);
        reset = 1'b1;
        tick();
        chk_st("reset_mid", hms(0, 0, 0), 1'b0);
        reset = 1'b0;
        tick();
        chk_st("resume", hms(0, 0, 1), 1'b0);

        // Up to 01:00:00, then borrow down
        ticks(3599);
        chk_st("one_hour", hms(1, 0, 0), 1'b0);
        updown = 1'b0;
        tick();
        chk_st("borrow", hms(0, 59, 59), 1'b0);
        ticks(3599);
        chk_st("down_zero", hms(0, 0, 0), 1'b0);
        tick();
        chk_st("borrow_wrap", hms(23, 59, 59), 1'b1);
        en = 1'b0;
        tick();
        chk_st("idle_wrap_clear", hms(23, 59, 59), 1'b0);

`ifdef CASCADE_COUNTER_ADJUST_EN
        adj_mode = 1'b1; en = 1'b1;
        for (int k = 0; k < 13; k++) pulse(2'd2, 1'b0, 1'b1);
        chk_st("adj_hours10", hms(10, 59, 59), 1'b0);
        pulse(2'd1, 1'b1, 1'b0);
        chk_st("adj_iso", hms(10, 0, 59), 1'b0);
        tick();
        chk_st("adj_en_frozen", hms(10, 0, 59), 1'b0);
        pulse(2'd1, 1'b1, 1'b1);
        chk_st("adj_both", hms(10, 0, 59), 1'b0);
        pulse(2'd3, 1'b1, 1'b0);
        chk_st("adj_sel_oob", hms(10, 0, 59), 1'b0);
        pulse(2'd0, 1'b1, 1'b0);
        chk_st("adj_sec_wrap", hms(10, 0, 0), 1'b0);
        for (int k = 0; k < 14; k++) pulse(2'd2, 1'b1, 1'b0);
        chk_st("adj_hours0", hms(0, 0, 0), 1'b0);
        pulse(2'd2, 1'b0, 1'b1);
        chk_st("adj_hours23", hms(23, 0, 0), 1'b0);
        adj_sel = 2'd1; adj_up = 1'b1; reset = 1'b1;
        tick();
        chk_st("reset_adj", hms(0, 0, 0), 1'b0);
        reset = 1'b0; adj_up = 1'b0; adj_mode = 1'b0;
        tick();
        chk_st("adj_exit_count", hms(23, 59, 59), 1'b1);
`else
        // Adjust inputs must be ignored; en counts every cycle
        adj_mode = 1'b1; adj_sel = 2'd2; adj_up = 1'b1; adj_down = 1'b0;
        en = 1'b1; updown = 1'b1;
        tick();
        chk_st("noadj_wrap", hms(0, 0, 0), 1'b1);
        adj_up = 1'b0; adj_down = 1'b1;
        tick();
        chk_st("noadj_step1", hms(0, 0, 1), 1'b0);
        adj_up = 1'b1;
        tick();
        chk_st("noadj_step2", hms(0, 0, 2), 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cascade_counter.md
# cascade_counter

Parametrised chain of up/down modulo counters with ripple carry/borrow between stages, generalising our single-stage binary counter to multi-digit time-of-day and timer use. Each stage has its own modulus, and a full-chain wrap raises a one-cycle pulse. An optional adjust mode lets the user step one stage without disturbing the others, for clock and alarm setting. The block sits between the 1 Hz tick generator and the display/alarm-compare logic.

## Interface
- STAGES, 3, number of cascaded stages; stage 0 is least significant.
- W, 6, bit width of each stage.
- MODS, {6'd24, 6'd60, 6'd60}, packed STAGES*W vector; stage i modulus is at bits [i*W +: W]. Each modulus is ≥ 2 and ≤ 2^W.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  count tick; one step per cycle while high.
- updown  in  1  1 = count up, 0 = count down.
- adj_mode  in  1  1 = adjust mode: counting frozen, adjust inputs active.
- adj_sel  in  max(1,$clog2(STAGES))  stage selected for adjustment.
- adj_up  in  1  step the selected stage +1 modulo its modulus, with no carry.
- adj_down  in  1  step the selected stage -1 modulo its modulus, with no borrow.
- count  out  STAGES*W  registered stage values, packed like MODS.
- wrap  out  1  registered one-cycle pulse when the whole chain wraps.

## Operation
- Stage i terminal: in up mode, value == MOD_i-1; in down mode, value == 0.
- Stage 0 steps when en=1 and adj_mode=0.
- Stage i>0 steps when stage 0 steps and every stage below i is terminal. This is a combinational carry chain evaluated from current register values.
- Up step: a terminal stage becomes 0; otherwise it increments by 1.
- Down step: a terminal stage becomes MOD_i-1; otherwise it decrements by 1.
- wrap is set on the next edge when a step occurs with all stages terminal. Examples: up from 23:59:59 to 00:00:00, and down from 00:00:00 to 23:59:59. Otherwise wrap is 0.
- Adjust (adj_mode=1):
  - en is ignored and wrap stays 0.
  - adj_up=1, adj_down=0 steps stage adj_sel up; adj_down=1, adj_up=0 steps it down. Wrap-around stays within that stage.
  - adj_up and adj_down both high: no change.
  - adj_sel ≥ STAGES: no change.
- updown may change on any cycle. It takes effect on the same edge.

## Timing
- Reset dominates all inputs: count = 0 and wrap = 0 on the edge where reset=1. This holds mid-count and mid-adjust.
- Latency: count updates on the edge that samples en, or adj_up/adj_down. wrap is valid in the cycle after that edge.
- All outputs are registered; there are no combinational input-to-output paths.
- adj_up/adj_down are level inputs sampled every cycle. The caller supplies single-cycle pulses, since debounce and edge-detect are upstream.
- A stage value is never outside 0..MOD_i-1 after reset.

## Configuration
- CASCADE_COUNTER_ADJUST_EN defined: adjust mode behaves as described above.
- CASCADE_COUNTER_ADJUST_EN undefined:
  - adj_mode, adj_sel, adj_up and adj_down remain as ports but are ignored.
  - en always counts, and no adjust logic is synthesised.

## Structure
- Package cascade_counter_pkg holds:
  - default stage width and the default MODS constant (24/60/60);
  - direction encodings DIR_UP=1'b1 and DIR_DOWN=1'b0;
  - a function returning the slice of stage i from a packed vector.
- One sub-module, mod_stage: a single W-bit modulo counter.
  - Inputs: step, dir, and modulus parameter.
  - Output: terminal flag.
- A generate loop instantiates STAGES copies of mod_stage. Carry gating and wrap logic live in the top level.

## Test plan
- Reset mid-count: count at 0x0C_1E_2A, assert reset for one cycle. Next cycle count=0 and wrap=0; counting resumes from 0 with en=1.
- Up rollover: load state 23:59:58 by stepping, en=1, updown=1 for 2 cycles. Expect 23:59:59, then 00:00:00 with wrap=1 for exactly one cycle.
- Down borrow: from 01:00:00, en=1, updown=0 for one cycle. Expect 00:59:59 and wrap=0. From 00:00:00, one step gives 23:59:59 and wrap=1.
- Adjust isolation (macro defined): at 10:59:59, adj_mode=1, adj_sel=1, adj_up pulse. Expect 10:00:59 with no carry into stage 2. en=1 during adjust leaves count unchanged.
- Adjust conflicts: adj_up=adj_down=1 gives no change; adj_sel=3 with STAGES=3 gives no change; adj_down on stage 2 at 0 gives 23.
- Macro undefined: adj_mode=1 with adj_up pulses and en=1 counts normally, one step per cycle.
